// File: rtl/traffic_gen_vc.sv
// Programmable packet-table traffic source for one router injection port.
// Streams flits from a filled table over a valid/ready link, with gap, loop and sent-count support.
module traffic_gen_vc #(
  parameter int DEPTH   = 1024,
  parameter int PTR_W   = 10,
  parameter int DEST_W  = 14,
  parameter int VC_W    = 2,
  parameter int NFLIT_W = 10,
  parameter int GAP_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_init,
  input  logic               fill_valid,
  input  logic [DEST_W-1:0]  fill_dest,
  input  logic [VC_W-1:0]    fill_vc,
  input  logic [NFLIT_W-1:0] fill_nflits,
  input  logic               start,
  input  logic [PTR_W:0]     cfg_total,
  input  logic               cfg_loop,
  input  logic [GAP_W-1:0]   cfg_gap,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_head,
  output logic               out_tail,
  output logic [VC_W-1:0]    out_vc,
  output logic [DEST_W-1:0]  out_dest,
  output logic               table_full,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pkts_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [DEST_W-1:0]  dest;
    logic [VC_W-1:0]    vc;
    logic [NFLIT_W-1:0] nflits;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             cur;
  entry_t             fill_entry;

  logic [1:0]         state;
  logic [PTR_W:0]     count;
  logic [PTR_W:0]     total_r;
  logic [PTR_W:0]     eff_total;
  logic [PTR_W-1:0]   head;
  logic [NFLIT_W-1:0] flit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [GAP_W-1:0]   gap_r;
  logic               loop_r;
  logic               do_fill;
  logic               fire;
  logic               last_flit;
  logic               last_pkt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fill_entry        = '0;
    fill_entry.dest   = fill_dest;
    fill_entry.vc     = fill_vc;
    fill_entry.nflits = (fill_nflits == '0) ? NFLIT_W'(1) : fill_nflits;
  end

  assign cur        = mem[head];
  assign eff_total  = (cfg_total < count) ? cfg_total : count;
  assign table_full = (count == FULL_COUNT);
  assign do_fill    = (state == S_IDLE) && fill_valid && !table_full && !cfg_init;

  assign out_valid  = (state == S_RUN);
  assign fire       = out_valid && out_ready;
  assign last_flit  = (flit_cnt == cur.nflits - NFLIT_W'(1));
  assign last_pkt   = (({1'b0, head} + (PTR_W+1)'(1)) == total_r);

  // Field outputs are gated so they read zero whenever no flit is presented.
  assign out_head   = out_valid && (flit_cnt == '0);
  assign out_tail   = out_valid && last_flit;
  assign out_vc     = out_valid ? cur.vc   : '0;
  assign out_dest   = out_valid ? cur.dest : '0;
  assign busy       = (state == S_RUN) || (state == S_GAP);
  assign done       = (state == S_DONE);

  // NOTE: the table RAM has no reset; it is only meaningful below count.
  always_ff @(posedge clk) begin
    if (do_fill) mem[count[PTR_W-1:0]] <= fill_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      total_r   <= '0;
      head      <= '0;
      flit_cnt  <= '0;
      gap_cnt   <= '0;
      gap_r     <= '0;
      loop_r    <= 1'b0;
      pkts_sent <= '0;
    end else if (cfg_init) begin
      state     <= S_IDLE;
      count     <= '0;
      head      <= '0;
      flit_cnt  <= '0;
      gap_cnt   <= '0;
      pkts_sent <= '0;
    end else begin
      if (do_fill) count <= count + (PTR_W+1)'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            total_r  <= eff_total;
            loop_r   <= cfg_loop;
            gap_r    <= cfg_gap;
            head     <= '0;
            flit_cnt <= '0;
            state    <= (eff_total == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (fire) begin
            if (!last_flit) begin
              flit_cnt <= flit_cnt + NFLIT_W'(1);
            end else begin
              flit_cnt <= '0;
              if (pkts_sent != 16'hFFFF) pkts_sent <= pkts_sent + 16'd1;
              if (last_pkt && !loop_r) begin
                state <= S_DONE;
              end else begin
                head <= last_pkt ? '0 : head + PTR_W'(1);
                if (gap_r != '0) begin
                  state   <= S_GAP;
                  gap_cnt <= gap_r - GAP_W'(1);
                end
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state   <= S_RUN;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_gen_vc.sv
// Directed bench for traffic_gen_vc: sequencing, stalls, gaps, totals, loop mode, table full and async reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_gen_vc;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_init;
  logic        fill_valid;
  logic [13:0] fill_dest;
  logic [1:0]  fill_vc;
  logic [9:0]  fill_nflits;
  logic        start;
  logic [10:0] cfg_total;
  logic        cfg_loop;
  logic [3:0]  cfg_gap;
  logic        out_valid;
  logic        out_ready;
  logic        out_head;
  logic        out_tail;
  logic [1:0]  out_vc;
  logic [13:0] out_dest;
  logic        table_full;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;

  int total = 0;
  int bad   = 0;

  logic [13:0] cap_dest [$];
  logic [1:0]  cap_vc   [$];
  logic        cap_head [$];
  logic        cap_tail [$];
  int          cap_cyc  [$];
  int          done_cyc;
  int          stall_err;

  always #5 clk = ~clk;

  traffic_gen_vc dut (
    .clk(clk), .rst_n(rst_n), .cfg_init(cfg_init), .fill_valid(fill_valid),
    .fill_dest(fill_dest), .fill_vc(fill_vc), .fill_nflits(fill_nflits),
    .start(start), .cfg_total(cfg_total), .cfg_loop(cfg_loop), .cfg_gap(cfg_gap),
    .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head), .out_tail(out_tail),
    .out_vc(out_vc), .out_dest(out_dest), .table_full(table_full), .busy(busy),
    .done(done), .pkts_sent(pkts_sent)
  );

  task automatic pulse_init();
    cfg_init = 1'b1;
    @(negedge clk);
    cfg_init = 1'b0;
  endtask

  task automatic fill(input logic [13:0] d, input logic [1:0] v, input logic [9:0] n);
    fill_valid = 1'b1; fill_dest = d; fill_vc = v; fill_nflits = n;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  task automatic do_start(input logic [10:0] t, input logic lp, input logic [3:0] g);
    cfg_total = t; cfg_loop = lp; cfg_gap = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic setup_table();
    pulse_init();
    fill(14'd5, 2'd1, 10'd1);
    fill(14'd9, 2'd2, 10'd3);
    fill(14'd3, 2'd0, 10'd2);
  endtask

  // Records every accepted flit and its cycle; stops when done rises or the budget runs out.
  task automatic collect(input bit stall_mode, input bit stop_on_done, input int max_cyc);
    logic pv, ph, pt;
    logic [1:0]  pvc;
    logic [13:0] pd;
    cap_dest.delete(); cap_vc.delete(); cap_head.delete(); cap_tail.delete(); cap_cyc.delete();
    done_cyc = -1; stall_err = 0;
    pv = 1'b0; ph = 1'b0; pt = 1'b0; pvc = '0; pd = '0;
    for (int c = 0; c < max_cyc; c++) begin
      if (stop_on_done && done) begin
        done_cyc = c;
        break;
      end
      if (pv && (out_valid !== 1'b1 || out_head !== ph || out_tail !== pt ||
                 out_vc !== pvc || out_dest !== pd)) stall_err++;
      out_ready = stall_mode ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (out_valid && out_ready) begin
        cap_dest.push_back(out_dest); cap_vc.push_back(out_vc);
        cap_head.push_back(out_head); cap_tail.push_back(out_tail);
        cap_cyc.push_back(c);
      end
      pv = out_valid && !out_ready;
      ph = out_head; pt = out_tail; pvc = out_vc; pd = out_dest;
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic check_three_packets(input string tag);
    int          n;
    logic [13:0] exp_dest [6] = '{14'd5, 14'd9, 14'd9, 14'd9, 14'd3, 14'd3};
    logic [1:0]  exp_vc   [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    logic        exp_head [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        exp_tail [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    n = cap_dest.size();
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL %s flit_count got=%0d want=6", tag, n);
    end
    for (int i = 0; i < 6 && i < n; i++) begin
      total++;
      if (cap_dest[i] !== exp_dest[i] || cap_vc[i] !== exp_vc[i] ||
          cap_head[i] !== exp_head[i] || cap_tail[i] !== exp_tail[i]) begin
        bad++;
        $display("FAIL %s flit%0d got dest=%0d vc=%0d h=%b t=%b want dest=%0d vc=%0d h=%b t=%b",
                 tag, i, cap_dest[i], cap_vc[i], cap_head[i], cap_tail[i],
                 exp_dest[i], exp_vc[i], exp_head[i], exp_tail[i]);
      end
    end
    total++;
    if (pkts_sent !== 16'd3) begin
      bad++; $display("FAIL %s pkts_sent got=%0d want=3", tag, pkts_sent);
    end
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || table_full !== 1'b0 ||
        pkts_sent !== 16'd0 || out_head !== 1'b0 || out_tail !== 1'b0 ||
        out_dest !== 14'd0 || out_vc !== 2'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%b b=%b f=%b p=%0d want all zero",
               out_valid, done, busy, table_full, pkts_sent);
    end
  endtask

  task automatic test_back_to_back();
    int exp_cyc [6] = '{0, 1, 2, 3, 4, 5};
    setup_table();
    do_start(11'd3, 1'b0, 4'd0);
    collect(1'b0, 1'b1, 40);
    check_three_packets("b2b");
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      total++;
      if (cap_cyc[i] !== exp_cyc[i]) begin
        bad++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", i, cap_cyc[i], exp_cyc[i]);
      end
    end
    total++;
    if (done_cyc !== 6) begin
      bad++; $display("FAIL b2b_done_cycle got=%0d want=6", done_cyc);
    end
  endtask

  task automatic test_stall();
    int exp_cyc [6] = '{0, 3, 4, 7, 8, 11};
    setup_table();
    do_start(11'd3, 1'b0, 4'd0);
    collect(1'b1, 1'b1, 60);
    check_three_packets("stall");
    total++;
    if (stall_err !== 0) begin
      bad++; $display("FAIL stall_hold got=%0d changes want=0", stall_err);
    end
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      total++;
      if (cap_cyc[i] !== exp_cyc[i]) begin
        bad++; $display("FAIL stall_cycle%0d got=%0d want=%0d", i, cap_cyc[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_gap();
    int exp_cyc [6] = '{0, 3, 4, 5, 8, 9};
    setup_table();
    do_start(11'd3, 1'b0, 4'd2);
    collect(1'b0, 1'b1, 60);
    check_three_packets("gap");
    for (int i = 0; i < 6 && i < cap_cyc.size(); i++) begin
      total++;
      if (cap_cyc[i] !== exp_cyc[i]) begin
        bad++; $display("FAIL gap_cycle%0d got=%0d want=%0d", i, cap_cyc[i], exp_cyc[i]);
      end
    end
    total++;
    if (done_cyc !== 10) begin
      bad++; $display("FAIL gap_done_cycle got=%0d want=10", done_cyc);
    end
  endtask

  task automatic test_total_clamp();
    int tails;
    setup_table();
    do_start(11'd7, 1'b0, 4'd0);
    collect(1'b0, 1'b1, 60);
    tails = 0;
    foreach (cap_tail[i]) if (cap_tail[i]) tails++;
    total++;
    if (tails !== 3 || pkts_sent !== 16'd3 || done !== 1'b1) begin
      bad++; $display("FAIL clamp got tails=%0d sent=%0d done=%b want 3 3 1", tails, pkts_sent, done);
    end
  endtask

  task automatic test_total_zero();
    setup_table();
    do_start(11'd0, 1'b0, 4'd0);
    total++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL zero_total got done=%b valid=%b want 1 0", done, out_valid);
    end
    start = 1'b1; cfg_total = 11'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL zero_hold%0d got done=%b valid=%b busy=%b want 1 0 0", c, done, out_valid, busy);
      end
    end
  endtask

  task automatic test_loop();
    int heads;
    int tails;
    logic [13:0] exp_d;
    setup_table();
    do_start(11'd2, 1'b1, 4'd0);
    collect(1'b0, 1'b0, 20);
    heads = 0; tails = 0;
    for (int i = 0; i < cap_dest.size(); i++) begin
      if (cap_tail[i]) tails++;
      if (cap_head[i]) begin
        exp_d = (heads % 2 == 0) ? 14'd5 : 14'd9;
        total++;
        if (cap_dest[i] !== exp_d) begin
          bad++; $display("FAIL loop_pkt%0d dest got=%0d want=%0d", heads, cap_dest[i], exp_d);
        end
        heads++;
      end
    end
    total++;
    if (tails !== 10 || pkts_sent !== 16'd10 || done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL loop_count got tails=%0d sent=%0d done=%b busy=%b want 10 10 0 1",
                      tails, pkts_sent, done, busy);
    end
    pulse_init();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pkts_sent !== 16'd0) begin
      bad++; $display("FAIL loop_init got valid=%b busy=%b done=%b sent=%0d want 0 0 0 0",
                      out_valid, busy, done, pkts_sent);
    end
  endtask

  task automatic test_table_full();
    pulse_init();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        total++;
        if (table_full !== 1'b0) begin
          bad++; $display("FAIL full_early got=%b want=0", table_full);
        end
      end
      fill(14'(i + 100), 2'(i % 4), 10'd4);
    end
    total++;
    if (table_full !== 1'b1) begin
      bad++; $display("FAIL full_flag got=%b want=1", table_full);
    end
    fill(14'h3abc, 2'd3, 10'd1);
    total++;
    if (table_full !== 1'b1) begin
      bad++; $display("FAIL full_after_extra got=%b want=1", table_full);
    end
    do_start(11'd2, 1'b0, 4'd0);
    total++;
    if (out_valid !== 1'b1 || out_dest !== 14'd100 || out_vc !== 2'd0 || out_head !== 1'b1) begin
      bad++; $display("FAIL full_entry0 got v=%b dest=%0d vc=%0d h=%b want 1 100 0 1",
                      out_valid, out_dest, out_vc, out_head);
    end
  endtask

  // Continues from the packet started by test_table_full (entries carry 4 flits each).
  task automatic test_async_reset();
    repeat (4) @(negedge clk);
    total++;
    if (pkts_sent !== 16'd1 || out_dest !== 14'd101 || out_head !== 1'b1) begin
      bad++; $display("FAIL pre_reset got sent=%0d dest=%0d h=%b want 1 101 1", pkts_sent, out_dest, out_head);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_head !== 1'b0 || out_tail !== 1'b0 || out_dest !== 14'd0 ||
        out_vc !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || table_full !== 1'b0 ||
        pkts_sent !== 16'd0) begin
      bad++; $display("FAIL async_reset got v=%b dest=%0d busy=%b full=%b sent=%0d want all zero",
                      out_valid, out_dest, busy, table_full, pkts_sent);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cfg_init = 1'b0; fill_valid = 1'b0; fill_dest = '0; fill_vc = '0;
    fill_nflits = '0; start = 1'b0; cfg_total = '0; cfg_loop = 1'b0; cfg_gap = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_back_to_back();
    test_stall();
    test_gap();
    test_total_clamp();
    test_total_zero();
    test_loop();
    test_table_full();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
